// File: rtl/vowel_stream_ctrl.sv
// Frame-based vowel removal on a valid/ready byte stream: fill a frame, compact it in one
// cycle, then replay the kept (optionally padded) bytes with out_last on the final byte.
module vowel_stream_ctrl #(
  parameter int unsigned FRAME_LEN        = 8,
  parameter logic [7:0]  PAD_CHAR         = 8'd95,
  parameter bit          PAD_OUT          = 1'b0,
  parameter bit          CASE_INSENSITIVE = 1'b0,
  localparam int unsigned CntW            = $clog2(FRAME_LEN + 1),
  localparam int unsigned IdxW            = $clog2(FRAME_LEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            out_last,
  output logic            frame_done,
  output logic [CntW-1:0] kept_cnt,
  output logic            busy
);

  typedef enum logic [1:0] {StFill, StFilter, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wr_idx_q, wr_idx_d;
  logic [CntW-1:0] rd_idx_q, rd_idx_d;
  logic [CntW-1:0] len_q, len_d;
  logic [7:0]      in_buf_q [FRAME_LEN];
  logic [7:0]      in_buf_d [FRAME_LEN];
  logic [7:0]      out_buf_q[FRAME_LEN];
  logic [7:0]      out_buf_d[FRAME_LEN];
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic            frame_done_q, frame_done_d;
  logic [CntW-1:0] kept_cnt_q, kept_cnt_d;
  logic            busy_q, busy_d;

  logic [7:0]      comp[FRAME_LEN];
  logic [CntW-1:0] comp_cnt;
  logic [CntW-1:0] drain_len;
  logic [CntW-1:0] rd_idx_nxt;

  function automatic logic is_drop(input logic [7:0] b);
    logic upper_vowel;
    logic lower_vowel;
    upper_vowel = b inside {8'h41, 8'h45, 8'h49, 8'h4F, 8'h55};
    lower_vowel = b inside {8'h61, 8'h65, 8'h69, 8'h6F, 8'h75};
    return (b == 8'h00) || upper_vowel || (CASE_INSENSITIVE && lower_vowel);
  endfunction

  // Stable compaction of the filled part of the frame; tail slots hold the fill byte.
  always_comb begin
    comp_cnt = '0;
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      comp[i] = PAD_OUT ? PAD_CHAR : 8'h00;
    end
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      if (CntW'(i) < wr_idx_q && !is_drop(in_buf_q[i])) begin
        comp[comp_cnt[IdxW-1:0]] = in_buf_q[i];
        comp_cnt                 = comp_cnt + CntW'(1);
      end
    end
    drain_len = PAD_OUT ? CntW'(FRAME_LEN) : comp_cnt;
  end

  assign in_ready   = (state_q == StFill);
  assign rd_idx_nxt = rd_idx_q + CntW'(1);

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    len_d        = len_q;
    in_buf_d     = in_buf_q;
    out_buf_d    = out_buf_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    kept_cnt_d   = kept_cnt_q;

    unique case (state_q)
      StFill: begin
        if (in_valid) begin
          in_buf_d[wr_idx_q[IdxW-1:0]] = in_data;
          wr_idx_d                     = wr_idx_q + CntW'(1);
          // A full frame closes exactly once, whether or not in_last accompanies it.
          if (wr_idx_q == CntW'(FRAME_LEN - 1) || in_last) begin
            state_d = StFilter;
          end
        end
      end
      StFilter: begin
        out_buf_d  = comp;
        kept_cnt_d = comp_cnt;
        wr_idx_d   = '0;
        rd_idx_d   = '0;
        len_d      = drain_len;
        if (drain_len == '0) begin
          frame_done_d = 1'b1;
          state_d      = StFill;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = comp[0];
          out_last_d  = (drain_len == CntW'(1));
          state_d     = StDrain;
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (out_last_q) begin
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            frame_done_d = 1'b1;
            state_d      = StFill;
          end else begin
            rd_idx_d   = rd_idx_nxt;
            out_data_d = out_buf_q[rd_idx_nxt[IdxW-1:0]];
            out_last_d = (rd_idx_nxt == len_q - CntW'(1));
          end
        end
      end
      default: state_d = StFill;
    endcase

    busy_d = (state_d != StFill) || (wr_idx_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFill;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      len_q        <= '0;
      in_buf_q     <= '{default: '0};
      out_buf_q    <= '{default: '0};
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      kept_cnt_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      len_q        <= len_d;
      in_buf_q     <= in_buf_d;
      out_buf_q    <= out_buf_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      kept_cnt_q   <= kept_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign kept_cnt   = kept_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vowel_stream_ctrl.sv
// Bench for vowel_stream_ctrl: three configurations (plain, padded, case-insensitive),
// table vectors, reset mid-drain, and random frames against a queue-based model.
module tb_vowel_stream_ctrl;
  localparam int unsigned FL = 8;
  localparam int unsigned CW = $clog2(FL + 1);

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int    d;
    string din;
    bit    last;
    string dout;
    int    kept;
    bit    stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic          in_valid[3], in_last[3], out_ready[3];
  logic [7:0]    in_data[3];
  logic          in_ready[3], out_valid[3], out_last[3], frame_done[3], busy[3];
  logic [7:0]    out_data[3];
  logic [CW-1:0] kept_cnt[3];

  int  total = 0;
  int  bad = 0;
  bq_t exp_q[3];
  int  pos[3];
  int  nout[3];
  vec_t vecs[10];

  always #5 clk = ~clk;

  vowel_stream_ctrl #(.FRAME_LEN(FL), .PAD_OUT(1'b0), .CASE_INSENSITIVE(1'b0)) u_plain (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
    .frame_done(frame_done[0]), .kept_cnt(kept_cnt[0]), .busy(busy[0]));

  vowel_stream_ctrl #(.FRAME_LEN(FL), .PAD_OUT(1'b1), .CASE_INSENSITIVE(1'b0)) u_pad (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
    .frame_done(frame_done[1]), .kept_cnt(kept_cnt[1]), .busy(busy[1]));

  vowel_stream_ctrl #(.FRAME_LEN(FL), .PAD_OUT(1'b0), .CASE_INSENSITIVE(1'b1)) u_ci (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .out_last(out_last[2]),
    .frame_done(frame_done[2]), .kept_cnt(kept_cnt[2]), .busy(busy[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // '#' in a table string stands for a 0x00 byte.
  function automatic bq_t str2q(input string s);
    bq_t        q;
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      q.push_back(c == 8'h23 ? 8'h00 : c);
    end
    return q;
  endfunction

  // d=1 pads to FL with '_', d=2 also drops lower-case vowels.
  function automatic void model(input int d, input bq_t din, output bq_t dout, output int kept);
    logic [7:0] b;
    logic [7:0] key;
    dout = {};
    foreach (din[i]) begin
      b   = din[i];
      key = (d == 2) ? (b & 8'hDF) : b;
      if (b != 8'h00 && !(key inside {8'h41, 8'h45, 8'h49, 8'h4F, 8'h55})) dout.push_back(b);
    end
    kept = dout.size();
    if (d == 1) while (dout.size() < FL) dout.push_back(8'h5F);
  endfunction

  // Called once per negedge: checks the output byte against the expected frame position.
  task automatic sample_out(input int d);
    if (out_valid[d] === 1'b1) begin
      if (pos[d] < exp_q[d].size()) begin
        check("out_data", out_data[d], exp_q[d][pos[d]]);
        check("out_last", out_last[d], pos[d] == exp_q[d].size() - 1);
      end else begin
        check("extra_out", pos[d], exp_q[d].size() - 1);
      end
      check("in_ready_drain", in_ready[d], 0);
      if (out_ready[d]) begin
        pos[d]++;
        nout[d]++;
      end
    end
  endtask

  task automatic send_bytes(input int d, input bq_t din, input bit last);
    int n;
    foreach (din[i]) begin
      in_valid[d] = 1'b1;
      in_data[d]  = din[i];
      in_last[d]  = last && (i == din.size() - 1);
      n = 0;
      forever begin
        @(negedge clk);
        sample_out(d);
        if (in_ready[d]) break;
        n++;
        if (n > 50) begin
          check("accept_timeout", n, 0);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
    in_data[d]  = 8'h00;
  endtask

  task automatic run_frame(input int d, input bq_t din, input bit last, input bq_t dout,
                           input int kept, input bit stall);
    int base;
    int n;
    bit done;
    exp_q[d]     = dout;
    pos[d]       = 0;
    base         = nout[d];
    out_ready[d] = 1'b1;
    send_bytes(d, din, last);
    @(negedge clk);
    sample_out(d);
    check("filter_valid", out_valid[d], 0);
    check("filter_done", frame_done[d], 0);
    @(posedge clk);
    #1;
    if (stall) out_ready[d] = 1'($urandom_range(0, 1));
    @(negedge clk);
    sample_out(d);
    if (dout.size() > 0) check("first_valid", out_valid[d], 1);
    else check("empty_done", frame_done[d], 1);
    done = frame_done[d];
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      out_ready[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      sample_out(d);
      done = frame_done[d];
      n++;
    end
    check("done_seen", done, 1);
    check("done_valid_low", out_valid[d], 0);
    check("out_count", nout[d] - base, dout.size());
    check("kept_cnt", kept_cnt[d], kept);
    check("in_ready_after", in_ready[d], 1);
    check("busy_after", busy[d], 0);
    @(posedge clk);
    #1;
    out_ready[d] = 1'b1;
    @(negedge clk);
    check("done_pulse", frame_done[d], 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bq_t din;
    bq_t dout;
    int  k;
    int  d;
    int  len;
    int  n;
    int  base;
    bit  last;
    string pool;

    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_last[i] = 1'b0; in_data[i] = 8'h00; out_ready[i] = 1'b1;
      pos[i] = 0; nout[i] = 0;
    end

    vecs[0] = '{0, "HELLOWOR", 1'b0, "HLLWR", 5, 1'b0};
    vecs[1] = '{0, "AEIOU", 1'b1, "", 0, 1'b0};
    vecs[2] = '{1, "CAT", 1'b1, "CT______", 2, 1'b0};
    vecs[3] = '{0, "BYTES#ZZ", 1'b0, "BYTSZZ", 6, 1'b1};
    vecs[4] = '{2, "aBe", 1'b1, "B", 1, 1'b0};
    vecs[5] = '{0, "aBe", 1'b1, "aBe", 3, 1'b0};
    vecs[6] = '{0, "QRSTUVWX", 1'b1, "QRSTVWX", 7, 1'b0};
    vecs[7] = '{1, "AEIOU", 1'b1, "________", 0, 1'b1};
    vecs[8] = '{2, "xyz", 1'b1, "xyz", 3, 1'b1};
    vecs[9] = '{0, "#", 1'b1, "", 0, 1'b0};

    #3;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", in_ready[i], 1);
      check("rst_out_valid", out_valid[i], 0);
      check("rst_out_data", out_data[i], 0);
      check("rst_out_last", out_last[i], 0);
      check("rst_frame_done", frame_done[i], 0);
      check("rst_kept_cnt", kept_cnt[i], 0);
      check("rst_busy", busy[i], 0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_frame(vecs[i].d, str2q(vecs[i].din), vecs[i].last, str2q(vecs[i].dout),
                vecs[i].kept, vecs[i].stall);
    end

    // Asynchronous reset while the third output byte is on the bus.
    exp_q[0] = str2q("HLLWR");
    pos[0]   = 0;
    base     = nout[0];
    send_bytes(0, str2q("HELLOWOR"), 1'b0);
    n = 0;
    while (nout[0] - base < 2 && n < 50) begin
      @(negedge clk);
      sample_out(0);
      n++;
    end
    check("rst_pre_count", nout[0] - base, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid[0], 0);
    check("async_out_data", out_data[0], 0);
    check("async_in_ready", in_ready[0], 1);
    check("async_busy", busy[0], 0);
    check("async_kept", kept_cnt[0], 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(0, str2q("XYZ"), 1'b1, str2q("XYZ"), 3, 1'b0);

    pool = "AEIOUaeiou#BCDXYZbcz";
    for (int r = 0; r < 40; r++) begin
      d   = $urandom_range(0, 2);
      len = $urandom_range(1, FL);
      din = {};
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 4) == 0) din.push_back(8'($urandom_range(0, 255)));
        else din.push_back(str2q(pool.substr(0, pool.len() - 1))[$urandom_range(0, 19)]);
      end
      last = (len < FL) ? 1'b1 : 1'($urandom_range(0, 1));
      model(d, din, dout, k);
      run_frame(d, din, last, dout, k, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
